// File: rtl/midi_msg_tx.sv
// midi_msg_tx: MIDI OUT message framer with byte FIFO and 8N1 serialiser (optional MIDI_TX_RUNNING_STATUS_EN)
module midi_msg_tx #(
  parameter int REG_CLK_FREQUENCY = 50_000_000,
  parameter int BAUD              = 31250,
  parameter int FIFO_DEPTH        = 8,
  parameter bit Invert_txd        = 1'b0
) (
  input  logic                          reg_clk,
  input  logic                          reset_reg_n,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [7:0]                    msg_status,
  input  logic [6:0]                    msg_data1,
  input  logic [6:0]                    msg_data2,
  output logic                          midi_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BIT_CYC = REG_CLK_FREQUENCY / BAUD;
  localparam int CW = BIT_CYC > 1 ? $clog2(BIT_CYC) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BIT_CYC - 1);
  localparam logic [PW:0] READY_MAX = (PW+1)'(FIFO_DEPTH - 3);
  localparam logic IDLE_LVL = !Invert_txd;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic ld_busy;
  logic [1:0] ld_cnt;
  logic [23:0] ld_q;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic [1:0] len;
  logic skip, accept, push, pop;
  assign len = !msg_status[7] ? 2'd1 :
               (msg_status[7:4] == 4'hC || msg_status[7:4] == 4'hD) ? 2'd2 :
               msg_status[7:4] != 4'hF ? 2'd3 :
               (msg_status == 8'hF1 || msg_status == 8'hF3) ? 2'd2 :
               msg_status == 8'hF2 ? 2'd3 : 2'd1;
  assign msg_ready = !ld_busy && fifo_level <= READY_MAX;
  assign accept = msg_valid && msg_ready;
  assign push = ld_busy;
  assign pop = (state == S_IDLE || (state == S_STOP && cnt == '0)) && fifo_level != '0;
  assign tx_busy = ld_busy || fifo_level != '0 || state != S_IDLE;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic is_voice;
  assign is_voice = msg_status[7] && msg_status[7:4] != 4'hF;
  assign skip = is_voice && msg_status == last_status;
  // Remember the last queued channel-voice status; system exclusive/common cancels it
  always_ff @(posedge reg_clk or negedge reset_reg_n)
    if (!reset_reg_n) last_status <= '0;
    else if (accept && is_voice) last_status <= msg_status;
    else if (accept && msg_status[7:3] == 5'b11110) last_status <= '0;
`else
  assign skip = 1'b0;
`endif
  // Loader: latch the whole message, then push one byte per cycle so a message is never split
  always_ff @(posedge reg_clk or negedge reset_reg_n)
    if (!reset_reg_n) begin
      ld_busy <= 1'b0;
      ld_cnt  <= '0;
      ld_q    <= '0;
    end else if (accept) begin
      ld_busy <= 1'b1;
      ld_cnt  <= len - {1'b0, skip};
      ld_q    <= skip ? {8'h00, 1'b0, msg_data2, 1'b0, msg_data1}
                      : {1'b0, msg_data2, 1'b0, msg_data1, msg_status};
    end else if (ld_busy) begin
      ld_busy <= ld_cnt != 2'd1;
      ld_cnt  <= ld_cnt - 2'd1;
      ld_q    <= {8'h00, ld_q[23:8]};
    end
  // FIFO storage has no reset; only the pointers and level define its contents
  always_ff @(posedge reg_clk)
    if (push) mem[wr_ptr] <= ld_q[7:0];
  // FIFO pointers wrap naturally; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge reg_clk or negedge reset_reg_n)
    if (!reset_reg_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
    end
  // Shifter: start, 8 data bits LSB first, stop; back-to-back frames when the FIFO has more
  always_ff @(posedge reg_clk or negedge reset_reg_n)
    if (!reset_reg_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      midi_txd <= IDLE_LVL;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          state    <= S_START;
          cnt      <= CNT_LOAD;
          sh       <= mem[rd_ptr];
          midi_txd <= Invert_txd;
        end
        S_START: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          state    <= S_DATA;
          cnt      <= CNT_LOAD;
          bit_idx  <= '0;
          midi_txd <= sh[0] ^ Invert_txd;
          sh       <= sh >> 1;
        end
        S_DATA: if (cnt != '0) cnt <= cnt - CW'(1);
        else if (bit_idx == 3'd7) begin
          state    <= S_STOP;
          cnt      <= CNT_LOAD;
          midi_txd <= !Invert_txd;
        end else begin
          cnt      <= CNT_LOAD;
          bit_idx  <= bit_idx + 3'd1;
          midi_txd <= sh[0] ^ Invert_txd;
          sh       <= sh >> 1;
        end
        S_STOP: if (cnt != '0) cnt <= cnt - CW'(1);
        else if (pop) begin
          state    <= S_START;
          cnt      <= CNT_LOAD;
          sh       <= mem[rd_ptr];
          midi_txd <= Invert_txd;
        end else begin
          state    <= S_IDLE;
          midi_txd <= IDLE_LVL;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_midi_msg_tx.sv
// tb_midi_msg_tx: randomized self-checking bench for midi_msg_tx with a line-level receiver model
module tb_midi_msg_tx;
  localparam int BIT = 16;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic msg_valid = 1'b0, valid_inv = 1'b0;
  logic [7:0] msg_status = '0;
  logic [6:0] msg_data1 = '0, msg_data2 = '0;
  logic msg_ready, ready_inv, txd, txd_inv, tx_busy, busy_inv;
  logic [3:0] fifo_level, level_inv;
  int errors = 0, checks = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int ferr = 0;
  int acc_cyc = 0;
  logic bp_mon = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int starts[$];
  int rx_t0, rx_rc;
  logic rx_ok;
  logic [7:0] rx_b;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_st = '0;
`endif

  midi_msg_tx #(.REG_CLK_FREQUENCY(500_000), .BAUD(31250), .FIFO_DEPTH(DEPTH), .Invert_txd(1'b0)) dut (
    .reg_clk(clk), .reset_reg_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .midi_txd(txd), .tx_busy(tx_busy), .fifo_level(fifo_level));

  midi_msg_tx #(.REG_CLK_FREQUENCY(500_000), .BAUD(31250), .FIFO_DEPTH(DEPTH), .Invert_txd(1'b1)) dut_inv (
    .reg_clk(clk), .reset_reg_n(rst_n), .msg_valid(valid_inv), .msg_ready(ready_inv),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .midi_txd(txd_inv), .tx_busy(busy_inv), .fifo_level(level_inv));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_cnt++;

  // UART receiver on the non-inverted line; frames cut by a reset are discarded
  initial forever begin
    @(negedge clk);
    if (rst_n && txd === 1'b0) begin
      rx_t0 = cyc;
      rx_rc = rst_cnt;
      repeat (BIT/2) @(negedge clk);
      rx_ok = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        rx_b[i] = txd;
      end
      repeat (BIT) @(negedge clk);
      rx_ok = rx_ok && (txd === 1'b1);
      if (rx_rc == rst_cnt) begin
        rx_q.push_back(rx_b);
        starts.push_back(rx_t0);
        if (!rx_ok) ferr++;
      end
    end
  end

  always @(negedge clk) if (bp_mon) begin
    checks++;
    if ((msg_ready && fifo_level > 4'(DEPTH - 3)) || fifo_level > 4'(DEPTH)) begin
      errors++;
      $display("FAIL backpressure_ready: ready=%b level=%0d, required ready=0 when free<3 and level<=%0d", msg_ready, fifo_level, DEPTH);
    end
  end

  function automatic int msg_len(input logic [7:0] s);
    if (!s[7]) return 1;
    case (s[7:4])
      4'hC, 4'hD: return 2;
      4'hF: return (s == 8'hF1 || s == 8'hF3) ? 2 : (s == 8'hF2) ? 3 : 1;
      default: return 3;
    endcase
  endfunction

  task automatic model_msg(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2);
    int n = msg_len(s);
    bit drop = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (s >= 8'h80 && s <= 8'hEF) begin
      drop = (s == last_st);
      last_st = s;
    end else if (s >= 8'hF0 && s <= 8'hF7) last_st = '0;
`endif
    if (!drop) exp_q.push_back(s);
    if (n > 1) exp_q.push_back({1'b0, d1});
    if (n > 2) exp_q.push_back({1'b0, d2});
  endtask

  task automatic send_msg(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2);
    int n = 0;
    msg_status = s;
    msg_data1 = d1;
    msg_data2 = d2;
    msg_valid = 1'b1;
    while (msg_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: msg_ready=%b, required 1 within 5000 cycles", msg_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
    model_msg(s, d1, d2);
    @(negedge clk);
    msg_valid = 1'b0;
    checks++;
    if (msg_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept: msg_ready=%b, required 0", msg_ready);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_stream(input string name);
    wait_idle();
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: tx_busy=%b, required 0", name, tx_busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %02h, required %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ferr != 0) begin
      errors++;
      $display("FAIL %s framing: %0d bad start/stop bits, required 0", name, ferr);
    end
    ferr = 0;
    rx_q.delete();
    exp_q.delete();
    starts.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b, required 1", txd); end
    if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", msg_ready); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
    if (txd_inv !== 1'b0) begin errors++; $display("FAIL reset_txd_inv: got %b, required 0", txd_inv); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_note_on();
    int fall;
    send_msg(8'h90, 7'h3C, 7'h64);
    wait_idle();
    fall = cyc;
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("FAIL note_on_frames: got %0d frames, required 3", starts.size());
    end else begin
      checks += 4;
      if (starts[0] != acc_cyc + 3) begin errors++; $display("FAIL note_on_latency: start at +%0d, required +3", starts[0] - acc_cyc); end
      if (starts[1] - starts[0] != 10*BIT) begin errors++; $display("FAIL note_on_gap1: got %0d, required %0d", starts[1] - starts[0], 10*BIT); end
      if (starts[2] - starts[1] != 10*BIT) begin errors++; $display("FAIL note_on_gap2: got %0d, required %0d", starts[2] - starts[1], 10*BIT); end
      if (fall - starts[0] != 30*BIT) begin errors++; $display("FAIL note_on_busy_fall: got %0d, required %0d", fall - starts[0], 30*BIT); end
    end
    check_stream("note_on");
  endtask

  task automatic test_prog_change();
    send_msg(8'hC5, 7'h07, 7'h7F);
    check_stream("prog_change");
  endtask

  task automatic test_running_status();
    send_msg(8'h90, 7'h3C, 7'h64);
    send_msg(8'h90, 7'h40, 7'h64);
    check_stream("rs_pair");
    send_msg(8'hF8, 7'h11, 7'h22);
    send_msg(8'h90, 7'h43, 7'h64);
    check_stream("rs_realtime");
    send_msg(8'hF0, 7'h00, 7'h00);
    send_msg(8'h90, 7'h43, 7'h64);
    check_stream("rs_sysex");
  endtask

  task automatic test_back_to_back();
    int k;
    bp_mon = 1'b1;
    for (int m = 0; m < 4; m++) begin
      k = $urandom_range(0, 4);
      send_msg({k == 0 ? 4'h8 : k == 1 ? 4'h9 : k == 2 ? 4'hA : k == 3 ? 4'hB : 4'hE, 4'($urandom_range(0, 15))},
               7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
    end
    wait_idle();
    bp_mon = 1'b0;
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != 10*BIT) begin
        errors++;
        $display("FAIL back_to_back_gap%0d: got %0d, required %0d", i, starts[i] - starts[i-1], 10*BIT);
      end
    end
    check_stream("back_to_back");
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [7:0] pool [6] = '{8'h90, 8'h91, 8'hC0, 8'hF8, 8'hF0, 8'h3C};
    for (int m = 0; m < 20; m++) begin
      s = $urandom_range(0, 1) ? pool[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      send_msg(s, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    check_stream("random");
  endtask

  task automatic test_reset_mid_byte();
    int n = 0;
    send_msg(8'h90, 7'h3C, 7'h64);
    while (starts.size() == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (starts.size() == 0) begin
      errors++;
      $display("FAIL reset_mid_start: no start bit seen, required one");
    end else begin
      while (cyc < starts[0] + 4*BIT + BIT/2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_mid_txd: got %b, required 1", txd); end
      if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_mid_level: got %0d, required 0", fifo_level); end
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, required 0", tx_busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.delete();
      rx_q.delete();
      starts.delete();
      ferr = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      last_st = '0;
`endif
      checks++;
      if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b, required 1", msg_ready); end
      repeat (12*BIT) @(negedge clk);
      checks++;
      if (rx_q.size() != 0 || txd !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_quiet: %0d frames, txd=%b, required 0 frames and idle 1", rx_q.size(), txd);
      end
    end
    send_msg(8'hB2, 7'h07, 7'h40);
    check_stream("after_reset");
  endtask

  task automatic test_invert();
    int n = 0;
    logic [7:0] v = 8'h55;
    checks++;
    if (txd_inv !== 1'b0) begin errors++; $display("FAIL inv_idle: got %b, required 0", txd_inv); end
    msg_status = v;
    valid_inv = 1'b1;
    while (ready_inv !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    valid_inv = 1'b0;
    n = 0;
    while (txd_inv !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    repeat (BIT/2) @(negedge clk);
    checks++;
    if (txd_inv !== 1'b1) begin errors++; $display("FAIL inv_start: got %b, required 1", txd_inv); end
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      checks++;
      if (txd_inv !== !v[i]) begin errors++; $display("FAIL inv_bit%0d: got %b, required %b", i, txd_inv, !v[i]); end
    end
    repeat (BIT) @(negedge clk);
    checks++;
    if (txd_inv !== 1'b0) begin errors++; $display("FAIL inv_stop: got %b, required 0", txd_inv); end
    n = 0;
    while (busy_inv !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (txd_inv !== 1'b0 || busy_inv !== 1'b0) begin
      errors++;
      $display("FAIL inv_end: txd=%b busy=%b, required 0 and 0", txd_inv, busy_inv);
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_prog_change();
    test_running_status();
    test_back_to_back();
    test_random();
    test_reset_mid_byte();
    test_invert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
